// File: rtl/frame_sequencer_if.sv
// frame_sequencer_if: control, fetch and core handshake bundle
// of the frame sequencer; master is the sequencer side.
interface frame_sequencer_if #(
  parameter int ROW_W = 10,
  parameter int CH_W  = 2,
  parameter int LEN_W = 20
);
  logic             start_i;
  logic             abort_i;
  logic             fetch_done_i;
  logic             core_done_i;
  logic             fetch_run_o;
  logic [LEN_W-1:0] fetch_len_o;
  logic [ROW_W-1:0] fetch_row_o;
  logic             core_run_o;
  logic [ROW_W-1:0] row_o;
  logic [CH_W-1:0]  ch_o;
  logic             busy_o;
  logic             done_o;
  logic             frame_done_o;
  logic             err_o;
  logic [2:0]       state_o;
  logic [2:0]       state_n_o;

  modport master (
    input  start_i, abort_i,
    input  fetch_done_i, core_done_i,
    output fetch_run_o, fetch_len_o,
    output fetch_row_o, core_run_o,
    output row_o, ch_o, busy_o, done_o,
    output frame_done_o, err_o,
    output state_o, state_n_o
  );

  modport slave (
    output start_i, abort_i,
    output fetch_done_i, core_done_i,
    input  fetch_run_o, fetch_len_o,
    input  fetch_row_o, core_run_o,
    input  row_o, ch_o, busy_o, done_o,
    input  frame_done_o, err_o,
    input  state_o, state_n_o
  );
endinterface

// File: rtl/frame_sequencer.sv
// frame_sequencer: row/channel sequencer for fetch and core passes.
// Define SEQ_WDT_EN to add the busy-state watchdog and ERR state.
module frame_sequencer #(
  parameter int MAX_ROW  = 540,
  parameter int MAX_COL  = 540,
  parameter int WIN_ROWS = 3,
  parameter int NUM_CH   = 1,
  parameter int ROW_W    = 10,
  parameter int CH_W     = 2,
  parameter int LEN_W    = 20
`ifdef SEQ_WDT_EN
  ,
  parameter int WDT_CYCLES = 65536
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  frame_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CORE  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [ROW_W-1:0] LAST_ROW =
    ROW_W'(MAX_ROW - WIN_ROWS);
  localparam logic [CH_W-1:0] LAST_CH =
    CH_W'(NUM_CH - 1);
  localparam logic [ROW_W-1:0] ROW_OFS =
    ROW_W'(WIN_ROWS - 1);
  localparam logic [LEN_W-1:0] FULL_LEN =
    LEN_W'(WIN_ROWS * MAX_COL);
  localparam logic [LEN_W-1:0] ROW_LEN =
    LEN_W'(MAX_COL);

  state_t           state;
  state_t           state_n;
  logic [ROW_W-1:0] row;
  logic [CH_W-1:0]  ch;
  logic             first;
  logic             frame_done;
  logic             last_row;
  logic             last_win;
  logic             timeout;

  assign last_row = (row == LAST_ROW);
  assign last_win = last_row && (ch == LAST_CH);

`ifdef SEQ_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST =
    WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt;
  logic             wdt_run;

  assign wdt_run = (state == S_FETCH) ||
                   (state == S_CORE);

  always_ff @(posedge clk) begin
    if (!rst_n || state_n != state || !wdt_run)
      wdt <= '0;
    else
      wdt <= wdt + 1'b1;
  end

  assign timeout = (wdt == WDT_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      frame_done <= (state == S_CORE) &&
                    (state_n == S_DONE);
    end
  end

  // A matching done wins over a watchdog expiry in the same cycle.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (bus.start_i) state_n = S_FETCH;
      end
      S_FETCH: begin
        if (bus.abort_i)           state_n = S_IDLE;
        else if (bus.fetch_done_i) state_n = S_CORE;
        else if (timeout)          state_n = S_ERR;
      end
      S_CORE: begin
        if (bus.abort_i)          state_n = S_IDLE;
        else if (bus.core_done_i)
          state_n = last_win ? S_DONE : S_FETCH;
        else if (timeout)         state_n = S_ERR;
      end
      S_DONE: begin
        if (bus.abort_i || bus.start_i)
          state_n = S_IDLE;
      end
      S_ERR: begin
        if (bus.abort_i || bus.start_i)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || state_n == S_IDLE) begin
      row   <= '0;
      ch    <= '0;
      first <= 1'b1;
    end else if (state == S_FETCH &&
                 state_n == S_CORE) begin
      first <= 1'b0;
    end else if (state == S_CORE &&
                 state_n == S_FETCH) begin
      if (last_row) begin
        row   <= '0;
        ch    <= ch + 1'b1;
        first <= 1'b1;
      end else begin
        row <= row + 1'b1;
      end
    end
  end

  assign bus.fetch_run_o  = (state == S_FETCH);
  assign bus.core_run_o   = (state == S_CORE);
  assign bus.busy_o       = (state == S_FETCH) ||
                            (state == S_CORE);
  assign bus.done_o       = (state == S_DONE);
  assign bus.frame_done_o = frame_done;
  assign bus.row_o        = row;
  assign bus.ch_o         = ch;
  assign bus.state_o      = state;
  assign bus.state_n_o    = state_n;

  // The first fetch of a channel primes the whole window.
  always_comb begin
    bus.fetch_len_o = '0;
    bus.fetch_row_o = '0;
    if (state == S_FETCH) begin
      if (first) begin
        bus.fetch_len_o = FULL_LEN;
      end else begin
        bus.fetch_len_o = ROW_LEN;
        bus.fetch_row_o = row + ROW_OFS;
      end
    end
  end

`ifdef SEQ_WDT_EN
  assign bus.err_o = (state == S_ERR);
`else
  assign bus.err_o = 1'b0;
`endif

endmodule
